// File: rtl/shift_unit_pipelined.sv
// Pipelined shift/rotate unit with valid/ready handshake, tag pass-through and flush.
// Left operations are right operations on a bit-reversed operand. The operand is reversed
// on entry and the result is reversed back in the last stage. Word mode works on the low
// 32 bits. Its operand is pre-extended on entry, so that every right-shift level works
// unchanged on the full XLEN width. The result is then sign-extended from bit 31 on exit.
module shift_unit_pipelined #(
  parameter int XLEN     = 32,
  parameter int STAGES   = 2,
  parameter int ID_W     = 3,
  parameter int WORD_OPS = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_data,
  input  logic [$clog2(XLEN)-1:0] in_shamt,
  input  logic [2:0]              in_op,
  input  logic                    in_word,
  input  logic [ID_W-1:0]         in_id,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_data,
  output logic [ID_W-1:0]         out_id
);

  localparam int SH_W = $clog2(XLEN);
  // shift levels handled per register stage (LSB levels first)
  localparam int GRP  = (SH_W + STAGES - 1) / STAGES;
  localparam int LAST = STAGES - 1;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  localparam logic [SH_W-1:0] WORD_SH_MASK = SH_W'(32'd31);

  function automatic logic [XLEN-1:0] rev_xlen_f(input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = d[XLEN-1-i];
    end
    return r;
  endfunction

  function automatic logic [31:0] rev32_f(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = d[31-i];
    end
    return r;
  endfunction

  function automatic logic is_left_f(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_ROL);
  endfunction

  function automatic logic is_rot_f(input logic [2:0] op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

  // One mux level: right shift/rotate by a fixed power-of-two amount.
  function automatic logic [XLEN-1:0] right_level_f(input logic [XLEN-1:0] d, input int amt,
                                                    input logic rot, input logic arith);
    logic [XLEN-1:0] r;
    if (rot) begin
      r = (d >> amt) | (d << (XLEN - amt));
    end else if (arith) begin
      r = XLEN'($signed(d) >>> amt);
    end else begin
      r = d >> amt;
    end
    return r;
  endfunction

  // Exit transform: undo the entry reversal, sign-extend word results, zero reserved ops.
  function automatic logic [XLEN-1:0] exit_f(input logic [XLEN-1:0] d, input logic [2:0] op,
                                             input logic word);
    logic [XLEN-1:0] r;
    logic [31:0]     low;
    if (word) begin
      if (is_left_f(op)) begin
        low = rev32_f(d[31:0]);
      end else begin
        low = d[31:0];
      end
      r = XLEN'($signed(low));
    end else begin
      low = d[31:0];
      if (is_left_f(op)) begin
        r = rev_xlen_f(d);
      end else begin
        r = d;
      end
    end
    case (op)
      OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: exit_f = r;
      default:                                exit_f = {XLEN{1'b0}};
    endcase
  endfunction

  // Stage registers
  logic [STAGES-1:0] valid_r;
  logic [XLEN-1:0]   data_r  [STAGES];
  logic [2:0]        op_r    [STAGES];
  logic              word_r  [STAGES];
  logic [SH_W-1:0]   shamt_r [STAGES];
  logic [ID_W-1:0]   id_r    [STAGES];

  // Values presented to each stage's input (stage 0 from the request port)
  logic              feed_valid_s [STAGES];
  logic [XLEN-1:0]   feed_data_s  [STAGES];
  logic [2:0]        feed_op_s    [STAGES];
  logic              feed_word_s  [STAGES];
  logic [SH_W-1:0]   feed_shamt_s [STAGES];
  logic [ID_W-1:0]   feed_id_s    [STAGES];
  logic [XLEN-1:0]   stage_res_s  [STAGES];
  logic [STAGES-1:0] can_take_s;

  logic            word_s;
  logic            left_s;
  logic [SH_W-1:0] shamt_s;
  logic [31:0]     low_s;
  logic [XLEN-1:0] entry_s;

  // Entry transform: word-mode operand preparation and bit reversal for left operations.
  always_comb begin
    word_s  = 1'b0;
    left_s  = is_left_f(in_op);
    shamt_s = in_shamt;
    low_s   = in_data[31:0];
    entry_s = in_data;
    if (WORD_OPS != 0) begin
      word_s = in_word;
    end else begin
      word_s = 1'b0;
    end
    if (word_s) begin
      shamt_s = in_shamt & WORD_SH_MASK;
      if (left_s) begin
        low_s = rev32_f(in_data[31:0]);
      end else begin
        low_s = in_data[31:0];
      end
      // Rotates see the word replicated, so wrapped bits come from the same word.
      if (is_rot_f(in_op)) begin
        entry_s = XLEN'({low_s, low_s});
      end else if (in_op == OP_SRA) begin
        entry_s = XLEN'($signed(low_s));
      end else begin
        entry_s = XLEN'(low_s);
      end
    end else begin
      shamt_s = in_shamt;
      low_s   = in_data[31:0];
      if (left_s) begin
        entry_s = rev_xlen_f(in_data);
      end else begin
        entry_s = in_data;
      end
    end
  end

  // Route the request into stage 0 and each register into the following stage.
  always_comb begin
    feed_valid_s[0] = in_valid;
    feed_data_s[0]  = entry_s;
    feed_op_s[0]    = in_op;
    feed_word_s[0]  = word_s;
    feed_shamt_s[0] = shamt_s;
    feed_id_s[0]    = in_id;
    for (int s = 1; s < STAGES; s++) begin
      feed_valid_s[s] = valid_r[s-1];
      feed_data_s[s]  = data_r[s-1];
      feed_op_s[s]    = op_r[s-1];
      feed_word_s[s]  = word_r[s-1];
      feed_shamt_s[s] = shamt_r[s-1];
      feed_id_s[s]    = id_r[s-1];
    end
  end

  // Per-stage datapath: apply this stage's group of levels; last stage adds the exit transform.
  always_comb begin
    logic [XLEN-1:0] acc_s;
    logic            rot_s;
    logic            arith_s;
    acc_s   = {XLEN{1'b0}};
    rot_s   = 1'b0;
    arith_s = 1'b0;
    for (int s = 0; s < STAGES; s++) begin
      acc_s   = feed_data_s[s];
      rot_s   = is_rot_f(feed_op_s[s]);
      arith_s = (feed_op_s[s] == OP_SRA);
      for (int k = 0; k < SH_W; k++) begin
        if (((k / GRP) == s) && feed_shamt_s[s][k]) begin
          acc_s = right_level_f(acc_s, 1 << k, rot_s, arith_s);
        end else begin
          acc_s = acc_s;
        end
      end
      if (s == LAST) begin
        stage_res_s[s] = exit_f(acc_s, feed_op_s[s], feed_word_s[s]);
      end else begin
        stage_res_s[s] = acc_s;
      end
    end
  end

  // A stage can load when empty or when its content moves on this cycle (bubble collapse).
  always_comb begin
    logic take_s;
    can_take_s   = {STAGES{1'b0}};
    take_s       = !valid_r[LAST] || out_ready;
    can_take_s[LAST] = take_s;
    for (int s = LAST - 1; s >= 0; s--) begin
      take_s        = !valid_r[s] || take_s;
      can_take_s[s] = take_s;
    end
  end

  assign in_ready  = can_take_s[0];
  assign out_valid = valid_r[LAST];
  assign out_data  = data_r[LAST];
  assign out_id    = id_r[LAST];

  // Stage register update: flush clears valids; payload loads only when a valid item moves in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {STAGES{1'b0}};
      for (int s = 0; s < STAGES; s++) begin
        data_r[s]  <= {XLEN{1'b0}};
        op_r[s]    <= 3'd0;
        word_r[s]  <= 1'b0;
        shamt_r[s] <= {SH_W{1'b0}};
        id_r[s]    <= {ID_W{1'b0}};
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (flush) begin
          valid_r[s] <= 1'b0;
        end else if (can_take_s[s]) begin
          valid_r[s] <= feed_valid_s[s];
        end else begin
          valid_r[s] <= valid_r[s];
        end
        if (can_take_s[s] && feed_valid_s[s]) begin
          data_r[s]  <= stage_res_s[s];
          op_r[s]    <= feed_op_s[s];
          word_r[s]  <= feed_word_s[s];
          shamt_r[s] <= feed_shamt_s[s];
          id_r[s]    <= feed_id_s[s];
        end else begin
          data_r[s]  <= data_r[s];
          op_r[s]    <= op_r[s];
          word_r[s]  <= word_r[s];
          shamt_r[s] <= shamt_r[s];
          id_r[s]    <= id_r[s];
        end
      end
    end
  end

endmodule
